pipe_hazard_ctrl: RTL and testbench

- Pipeline sequencer for the 5-stage RV32I core (IF/ID/EX/MEM/WB).
- Generates the stage enables and bubble/flush controls, and drives the `clr` input of the ID-stage control decoder.
- Resolves three hazard classes in fixed priority: data-memory wait, taken-branch/jump flush, load-use stall.
- Keeps a saturating stall-cycle counter for performance measurement.

---
 rtl/rv_pipe_pkg.sv | 38 +++
 rtl/rv_opnd_use.sv | 21 ++
 rtl/pipe_hazard_ctrl.sv | 156 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pipe_pkg.sv
// Shared pipeline definitions for the RV32I core: opcode encodings used by the
// decoder and hazard logic, sequencer states and the stage-control bundle.
package rv_pipe_pkg;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_ALUI   = 7'b0010011;
   localparam logic [6:0] OP_ALUR   = 7'b0110011;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_LU_STALL = 2'd1,
      ST_MEM_WAIT = 2'd2
   } pipe_state_t;

   typedef struct packed {
      logic pc_en;
      logic ifid_en;
      logic ifid_clr;
      logic id_clr;
      logic ex_en;
      logic mem_en;
   } stage_ctl_t;

   // Canned control patterns, bit order pc_en..mem_en as in stage_ctl_t.
   localparam stage_ctl_t CTL_RUN   = 6'b110011;
   localparam stage_ctl_t CTL_FLUSH = 6'b111111;
   localparam stage_ctl_t CTL_LU    = 6'b000111;
   localparam stage_ctl_t CTL_HOLD  = 6'b000000;
   localparam stage_ctl_t CTL_RESET = 6'b001100;

endpackage

// File: rtl/rv_opnd_use.sv
// Opcode -> source-operand usage; shared by the hazard sequencer and the
// forwarding unit so both agree on which rs fields are live.
module rv_opnd_use
   import rv_pipe_pkg::*;
(
   input  logic [6:0] opcode,
   output logic       uses_rs1,
   output logic       uses_rs2
);

   always_comb begin
      uses_rs1 = 1'b1;
      uses_rs2 = 1'b0;
      case (opcode)
         OP_LUI, OP_AUIPC, OP_JAL:      uses_rs1 = 1'b0;
         OP_ALUR, OP_STORE, OP_BRANCH:  uses_rs2 = 1'b1;
         default:                       ;
      endcase
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Five-stage pipeline sequencer: stage enables, bubbles and flushes for memory
// wait, taken branch and load-use. PIPE_HAZARD_NOFWD_EN adds RAW stalls.
module pipe_hazard_ctrl
   import rv_pipe_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT  = 64,
   parameter int unsigned LU_STALL_CYC = 1,
   parameter int unsigned CNT_W        = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [6:0]       id_opcode,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic [4:0]       ex_rd,
   input  logic             ex_memread,
   input  logic             ex_regwrite,
   input  logic [4:0]       mem_rd,
   input  logic             mem_regwrite,
   input  logic             br_taken,
   input  logic             mem_req,
   input  logic             mem_ready,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             ifid_clr,
   output logic             id_clr,
   output logic             ex_en,
   output logic             mem_en,
   output logic             mem_err,
   output logic [CNT_W-1:0] stall_cnt,
   output pipe_state_t      dbg_state
);

   localparam int TMO_W = $clog2(MEM_TIMEOUT + 1);
   localparam int LU_W  = 2;
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);
   localparam logic [LU_W-1:0]  LU_LAST  = LU_W'(LU_STALL_CYC);

   pipe_state_t      state_q, state_d;
   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic [LU_W-1:0]  lu_q, lu_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   stage_ctl_t ctl;
   logic       err;
   logic       uses_rs1, uses_rs2;
   logic       ex_hit, load_use, raw_stall, mem_stall;

   rv_opnd_use u_opnd_use (
      .opcode   (id_opcode),
      .uses_rs1 (uses_rs1),
      .uses_rs2 (uses_rs2)
   );

   assign ex_hit    = (ex_rd != 5'd0) &
                      ((uses_rs1 & (ex_rd == id_rs1)) | (uses_rs2 & (ex_rd == id_rs2)));
   assign load_use  = ex_memread & ex_hit;
   assign mem_stall = mem_req & ~mem_ready;

`ifdef PIPE_HAZARD_NOFWD_EN
   logic mem_hit;
   assign mem_hit   = (mem_rd != 5'd0) &
                      ((uses_rs1 & (mem_rd == id_rs1)) | (uses_rs2 & (mem_rd == id_rs2)));
   assign raw_stall = (ex_regwrite & ex_hit) | (mem_regwrite & mem_hit);
`else
   logic unused_nofwd;
   assign unused_nofwd = ^{ex_regwrite, mem_rd, mem_regwrite};
   assign raw_stall    = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      tmo_d   = '0;
      lu_d    = '0;
      ctl     = CTL_RUN;
      err     = 1'b0;
      case (state_q)
         ST_RUN, ST_LU_STALL: begin
            if (mem_stall) begin
               // EX is frozen, so a coincident taken branch survives the wait.
               ctl     = CTL_HOLD;
               state_d = ST_MEM_WAIT;
               tmo_d   = TMO_W'(1);
            end else if (br_taken) begin
               ctl     = CTL_FLUSH;
               state_d = ST_RUN;
            end else if (state_q == ST_LU_STALL) begin
               ctl  = CTL_LU;
               lu_d = lu_q + 2'd1;
               if (lu_d == LU_LAST) begin
                  state_d = ST_RUN;
               end
            end else if (load_use) begin
               ctl = CTL_LU;
               if (LU_STALL_CYC > 1) begin
                  state_d = ST_LU_STALL;
                  lu_d    = 2'd1;
               end
            end else if (raw_stall) begin
               ctl = CTL_LU;
            end
         end
         ST_MEM_WAIT: begin
            ctl = CTL_HOLD;
            if (mem_ready) begin
               ctl     = CTL_RUN;
               state_d = ST_RUN;
            end else if (tmo_q >= TMO_LAST) begin
               // Give up on the access: release the pipe and flag the loss.
               ctl     = CTL_RUN;
               err     = 1'b1;
               state_d = ST_RUN;
            end else begin
               tmo_d = tmo_q + TMO_W'(1);
            end
         end
         default: state_d = ST_RUN;
      endcase
      if (rst) begin
         ctl = CTL_RESET;
         err = 1'b0;
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (!ctl.pc_en && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_RUN;
         tmo_q   <= '0;
         lu_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         tmo_q   <= tmo_d;
         lu_q    <= lu_d;
         cnt_q   <= cnt_d;
      end
   end

   assign pc_en     = ctl.pc_en;
   assign ifid_en   = ctl.ifid_en;
   assign ifid_clr  = ctl.ifid_clr;
   assign id_clr    = ctl.id_clr;
   assign ex_en     = ctl.ex_en;
   assign mem_en    = ctl.mem_en;
   assign mem_err   = err;
   assign stall_cnt = cnt_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: two instances (single-cycle and 3-cycle load-use,
// 32-bit and 4-bit stall counter) driven in lockstep against a behavioural model.
module tb_pipe_hazard_ctrl;
   import rv_pipe_pkg::*;

   localparam int MEM_TMO = 4;

   localparam logic [6:0] OPC_LUI   = 7'h37;
   localparam logic [6:0] OPC_AUIPC = 7'h17;
   localparam logic [6:0] OPC_JAL   = 7'h6f;
   localparam logic [6:0] OPC_JALR  = 7'h67;
   localparam logic [6:0] OPC_BR    = 7'h63;
   localparam logic [6:0] OPC_LD    = 7'h03;
   localparam logic [6:0] OPC_ST    = 7'h23;
   localparam logic [6:0] OPC_ALUI  = 7'h13;
   localparam logic [6:0] OPC_ALUR  = 7'h33;
   localparam logic [6:0] OPC_SYS   = 7'h73;

   // {pc_en, ifid_en, ifid_clr, id_clr, ex_en, mem_en, mem_err}
   localparam logic [6:0] C_RST  = 7'b0011000;
   localparam logic [6:0] C_RUN  = 7'b1100110;
   localparam logic [6:0] C_FL   = 7'b1111110;
   localparam logic [6:0] C_LU   = 7'b0001110;
   localparam logic [6:0] C_HOLD = 7'b0000000;
   localparam logic [6:0] C_ERR  = 7'b1100111;

   logic        clk = 1'b0;
   logic        rst;
   logic [6:0]  id_opcode;
   logic [4:0]  id_rs1, id_rs2, ex_rd, mem_rd;
   logic        ex_memread, ex_regwrite, mem_regwrite, br_taken, mem_req, mem_ready;

   logic        pc_en [2];
   logic        ifid_en [2];
   logic        ifid_clr [2];
   logic        id_clr [2];
   logic        ex_en [2];
   logic        mem_en [2];
   logic        mem_err [2];
   logic [31:0] stall_cnt0;
   logic [3:0]  stall_cnt1;
   pipe_state_t act_st [2];

   logic [6:0]  act_ctl [2];
   logic [63:0] act_cnt [2];

   int          n_checks = 0;
   int          n_fail   = 0;

   int          lu_cyc  [2] = '{1, 3};
   longint      cnt_max [2] = '{64'hFFFF_FFFF, 15};
   int          m_wait   [2] = '{0, 0};
   int          m_waited [2] = '{0, 0};
   int          m_left   [2] = '{0, 0};
   longint      m_cnt    [2] = '{0, 0};

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.MEM_TIMEOUT(MEM_TMO), .LU_STALL_CYC(1), .CNT_W(32)) dut0 (
      .clk(clk), .rst(rst), .id_opcode(id_opcode), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .ex_rd(ex_rd), .ex_memread(ex_memread), .ex_regwrite(ex_regwrite),
      .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .br_taken(br_taken),
      .mem_req(mem_req), .mem_ready(mem_ready),
      .pc_en(pc_en[0]), .ifid_en(ifid_en[0]), .ifid_clr(ifid_clr[0]), .id_clr(id_clr[0]),
      .ex_en(ex_en[0]), .mem_en(mem_en[0]), .mem_err(mem_err[0]),
      .stall_cnt(stall_cnt0), .dbg_state(act_st[0])
   );

   pipe_hazard_ctrl #(.MEM_TIMEOUT(MEM_TMO), .LU_STALL_CYC(3), .CNT_W(4)) dut1 (
      .clk(clk), .rst(rst), .id_opcode(id_opcode), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .ex_rd(ex_rd), .ex_memread(ex_memread), .ex_regwrite(ex_regwrite),
      .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .br_taken(br_taken),
      .mem_req(mem_req), .mem_ready(mem_ready),
      .pc_en(pc_en[1]), .ifid_en(ifid_en[1]), .ifid_clr(ifid_clr[1]), .id_clr(id_clr[1]),
      .ex_en(ex_en[1]), .mem_en(mem_en[1]), .mem_err(mem_err[1]),
      .stall_cnt(stall_cnt1), .dbg_state(act_st[1])
   );

   always_comb begin
      for (int k = 0; k < 2; k++) begin
         act_ctl[k] = {pc_en[k], ifid_en[k], ifid_clr[k], id_clr[k], ex_en[k], mem_en[k], mem_err[k]};
      end
      act_cnt[0] = 64'(stall_cnt0);
      act_cnt[1] = 64'(stall_cnt1);
   end

   task automatic check(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s[%0d] got=%0h expected=%0h at %0t", name, idx, act, exp, $time);
      end
   endtask

   // ---------------- behavioural reference model ----------------
   function automatic bit reads_reg(input logic [4:0] r);
      bit u1;
      bit u2;
      u1 = !(id_opcode inside {OPC_LUI, OPC_AUIPC, OPC_JAL});
      u2 = id_opcode inside {OPC_ALUR, OPC_ST, OPC_BR};
      return (r != 5'd0) && ((u1 && r == id_rs1) || (u2 && r == id_rs2));
   endfunction

   function automatic bit raw_hazard();
`ifdef PIPE_HAZARD_NOFWD_EN
      return (ex_regwrite && reads_reg(ex_rd)) || (mem_regwrite && reads_reg(mem_rd));
`else
      return 1'b0;
`endif
   endfunction

   function automatic pipe_state_t exp_state(input int k);
      if (m_wait[k] != 0) return ST_MEM_WAIT;
      if (m_left[k] > 0)  return ST_LU_STALL;
      return ST_RUN;
   endfunction

   task automatic model_step(input int k, output logic [6:0] e);
      if (rst) begin
         e = C_RST;
         m_wait[k] = 0; m_waited[k] = 0; m_left[k] = 0; m_cnt[k] = 0;
      end else begin
         if (m_wait[k] != 0) begin
            if (mem_ready) begin
               e = C_RUN; m_wait[k] = 0;
            end else if (m_waited[k] + 1 >= MEM_TMO) begin
               e = C_ERR; m_wait[k] = 0;
            end else begin
               e = C_HOLD; m_waited[k]++;
            end
         end else if (mem_req && !mem_ready) begin
            e = C_HOLD; m_wait[k] = 1; m_waited[k] = 1; m_left[k] = 0;
         end else if (br_taken) begin
            e = C_FL; m_left[k] = 0;
         end else if (m_left[k] > 0) begin
            e = C_LU; m_left[k]--;
         end else if (ex_memread && reads_reg(ex_rd)) begin
            e = C_LU; m_left[k] = lu_cyc[k] - 1;
         end else if (raw_hazard()) begin
            e = C_LU;
         end else begin
            e = C_RUN;
         end
         if (e[6] == 1'b0 && m_cnt[k] < cnt_max[k]) m_cnt[k]++;
      end
   endtask

   task automatic sample_all();
      logic [6:0] e;
      for (int k = 0; k < 2; k++) begin
         check("state", k, 64'(act_st[k]), 64'(exp_state(k)));
         check("stall_cnt", k, act_cnt[k], 64'(m_cnt[k]));
         model_step(k, e);
         check("ctl", k, 64'(act_ctl[k]), 64'(e));
      end
   endtask

   task automatic end_cycle();
      sample_all();
      @(posedge clk);
      #1;
   endtask

   task automatic tick();
      @(negedge clk);
      end_cycle();
   endtask

   task automatic drive(input logic r, input logic [6:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] exrd, input logic memrd, input logic regwr,
                        input logic br, input logic req, input logic rdy);
      rst = r; id_opcode = op; id_rs1 = rs1; id_rs2 = rs2; ex_rd = exrd;
      ex_memread = memrd; ex_regwrite = regwr; mem_rd = 5'd0; mem_regwrite = 1'b0;
      br_taken = br; mem_req = req; mem_ready = rdy;
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic        r;
      logic [6:0]  op;
      logic [4:0]  rs1, rs2, exrd;
      logic        memrd, regwr, br, req, rdy;
      logic [6:0]  e_ctl;
      int          e_cnt;
      pipe_state_t e_st;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic r, input logic [6:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [4:0] exrd, input logic memrd, input logic regwr,
                      input logic br, input logic req, input logic rdy,
                      input logic [6:0] e_ctl, input int e_cnt, input pipe_state_t e_st);
      vec_t v;
      v.r = r; v.op = op; v.rs1 = rs1; v.rs2 = rs2; v.exrd = exrd;
      v.memrd = memrd; v.regwr = regwr; v.br = br; v.req = req; v.rdy = rdy;
      v.e_ctl = e_ctl; v.e_cnt = e_cnt; v.e_st = e_st;
      tbl.push_back(v);
   endtask

   logic [6:0] ops [10] = '{OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BR,
                            OPC_LD, OPC_ST, OPC_ALUI, OPC_ALUR, OPC_SYS};

   initial begin
      #5_000_000;
      n_fail++;
      $display("FAIL watchdog simulation did not finish");
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      drive(1, OPC_ALUI, 5'd1, 5'd0, 5'd0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1;

      add(1, OPC_ALUI, 1, 0, 0, 0, 0, 0, 0, 0, C_RST,  0, ST_RUN);
      add(0, OPC_ALUI, 1, 0, 0, 0, 0, 0, 0, 0, C_RUN,  0, ST_RUN);
      add(0, OPC_ALUR, 1, 5, 5, 1, 1, 0, 0, 0, C_LU,   0, ST_RUN);
      add(0, OPC_ALUI, 1, 0, 0, 0, 0, 0, 0, 0, C_RUN,  1, ST_RUN);
      add(0, OPC_ALUR, 0, 0, 0, 1, 1, 0, 0, 0, C_RUN,  1, ST_RUN);
      add(0, OPC_LUI,  7, 0, 7, 1, 1, 0, 0, 0, C_RUN,  1, ST_RUN);
      add(0, OPC_JAL,  7, 7, 7, 1, 1, 0, 0, 0, C_RUN,  1, ST_RUN);
      add(0, OPC_ALUI, 3, 7, 7, 1, 1, 0, 0, 0, C_RUN,  1, ST_RUN);
      add(0, OPC_ST,   3, 9, 9, 1, 1, 0, 0, 0, C_LU,   1, ST_RUN);
      add(0, OPC_ALUR, 5, 0, 5, 1, 1, 1, 0, 0, C_FL,   2, ST_RUN);
      add(0, OPC_ALUI, 1, 0, 0, 0, 0, 0, 1, 0, C_HOLD, 2, ST_RUN);
      add(0, OPC_ALUI, 1, 0, 0, 0, 0, 0, 1, 0, C_HOLD, 3, ST_MEM_WAIT);
      add(0, OPC_ALUI, 1, 0, 0, 0, 0, 0, 1, 0, C_HOLD, 4, ST_MEM_WAIT);
      add(0, OPC_ALUI, 1, 0, 0, 0, 0, 0, 1, 1, C_RUN,  5, ST_MEM_WAIT);
      add(0, OPC_ALUI, 1, 0, 0, 0, 0, 0, 0, 0, C_RUN,  5, ST_RUN);
      add(0, OPC_ALUI, 1, 0, 0, 0, 0, 0, 1, 0, C_HOLD, 5, ST_RUN);
      add(0, OPC_ALUI, 1, 0, 0, 0, 0, 0, 1, 0, C_HOLD, 6, ST_MEM_WAIT);
      add(0, OPC_ALUI, 1, 0, 0, 0, 0, 0, 1, 0, C_HOLD, 7, ST_MEM_WAIT);
      add(0, OPC_ALUI, 1, 0, 0, 0, 0, 0, 1, 0, C_ERR,  8, ST_MEM_WAIT);
      add(0, OPC_ALUI, 1, 0, 0, 0, 0, 0, 0, 0, C_RUN,  8, ST_RUN);
      add(0, OPC_ALUI, 1, 0, 0, 0, 0, 0, 1, 0, C_HOLD, 8, ST_RUN);
      add(0, OPC_ALUI, 1, 0, 0, 0, 0, 0, 1, 0, C_HOLD, 9, ST_MEM_WAIT);
      add(1, OPC_ALUI, 1, 0, 0, 0, 0, 0, 1, 0, C_RST, 10, ST_MEM_WAIT);
      add(0, OPC_ALUI, 1, 0, 0, 0, 0, 0, 0, 0, C_RUN,  0, ST_RUN);
      add(0, OPC_ALUI, 1, 0, 0, 0, 0, 0, 1, 1, C_RUN,  0, ST_RUN);
`ifdef PIPE_HAZARD_NOFWD_EN
      add(0, OPC_ALUR, 4, 0, 4, 0, 1, 0, 0, 0, C_LU,   0, ST_RUN);
      add(0, OPC_ALUI, 1, 0, 0, 0, 0, 0, 0, 0, C_RUN,  1, ST_RUN);
`else
      add(0, OPC_ALUR, 4, 0, 4, 0, 1, 0, 0, 0, C_RUN,  0, ST_RUN);
      add(0, OPC_ALUI, 1, 0, 0, 0, 0, 0, 0, 0, C_RUN,  0, ST_RUN);
`endif

      foreach (tbl[i]) begin
         drive(tbl[i].r, tbl[i].op, tbl[i].rs1, tbl[i].rs2, tbl[i].exrd,
               tbl[i].memrd, tbl[i].regwr, tbl[i].br, tbl[i].req, tbl[i].rdy);
         @(negedge clk);
         check("vec_ctl", i, 64'(act_ctl[0]), 64'(tbl[i].e_ctl));
         check("vec_cnt", i, act_cnt[0], 64'(tbl[i].e_cnt));
         check("vec_state", i, 64'(act_st[0]), 64'(tbl[i].e_st));
         end_cycle();
      end

      // Taken branch while the 3-cycle instance sits in LU_STALL.
      drive(1, OPC_ALUI, 1, 0, 0, 0, 0, 0, 0, 0);
      tick();
      drive(0, OPC_ALUR, 1, 5, 5, 1, 1, 0, 0, 0);
      tick();
      drive(0, OPC_ALUI, 1, 0, 0, 0, 0, 1, 0, 0);
      @(negedge clk);
      check("lu_br_state", 1, 64'(act_st[1]), 64'(ST_LU_STALL));
      check("lu_br_ctl", 1, 64'(act_ctl[1]), 64'(C_FL));
      end_cycle();
      drive(0, OPC_ALUI, 1, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      check("lu_br_exit_state", 1, 64'(act_st[1]), 64'(ST_RUN));
      check("lu_br_exit_ctl", 1, 64'(act_ctl[1]), 64'(C_RUN));
      end_cycle();

      // Long run of stalls: 4-bit counter must stick at all-ones.
      drive(1, OPC_ALUI, 1, 0, 0, 0, 0, 0, 0, 0);
      tick();
      drive(0, OPC_ALUR, 6, 2, 6, 1, 1, 0, 0, 0);
      repeat (20) tick();
      drive(0, OPC_ALUI, 1, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      check("sat_cnt4", 1, act_cnt[1], 64'd15);
      check("sat_cnt32", 0, act_cnt[0], 64'd20);
      end_cycle();

      // Randomised traffic against the model.
      for (int n = 0; n < 2000; n++) begin
         rst          = ($urandom_range(0, 99) == 0);
         id_opcode    = ($urandom_range(0, 10) == 10) ? 7'($urandom) : ops[$urandom_range(0, 9)];
         id_rs1       = 5'($urandom_range(0, 3));
         id_rs2       = 5'($urandom_range(0, 3));
         ex_rd        = 5'($urandom_range(0, 3));
         mem_rd       = 5'($urandom_range(0, 3));
         ex_memread   = ($urandom_range(0, 2) == 0);
         ex_regwrite  = ($urandom_range(0, 1) == 0);
         mem_regwrite = ($urandom_range(0, 1) == 0);
         br_taken     = ($urandom_range(0, 7) == 0);
         mem_req      = ($urandom_range(0, 5) == 0);
         mem_ready    = ($urandom_range(0, 3) == 0);
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
